// File: rtl/regfile_sequencer.sv
// regfile_sequencer: one-at-a-time READ/COPY/SWAP/FILL command engine driving a 2R/1W register file
// Optional REGFILE_SEQ_PROTECT_R0_EN: register 0 reads as zero and writes to it are suppressed.
module regfile_sequencer #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [4:0]           cmd_ra,
    input  logic [4:0]           cmd_rb,
    input  logic [DATAWIDTH-1:0] cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic [4:0]           rf_readReg1,
    output logic [4:0]           rf_readReg2,
    output logic [4:0]           rf_writeReg,
    output logic [DATAWIDTH-1:0] rf_writeData,
    output logic                 rf_write,
    input  logic [DATAWIDTH-1:0] rf_readData1,
    input  logic [DATAWIDTH-1:0] rf_readData2
);
`ifdef REGFILE_SEQ_PROTECT_R0_EN
    localparam bit PROTECT_R0 = 1'b1;
`else
    localparam bit PROTECT_R0 = 1'b0;
`endif
    localparam logic [1:0] OP_READ = 2'd0, OP_COPY = 2'd1, OP_SWAP = 2'd2, OP_FILL = 2'd3;
    typedef enum logic [2:0] {IDLE, RD, CAP, WR1, WR2, FILL, RESP} state_t;
    state_t                 state_q;
    logic [1:0]             op_q;
    logic [4:0]             ra_q, rb_q, ptr_q, ptr_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [DATAWIDTH-1:0]   data_q, a_q, b_q, cap_a_d, cap_b_d;
    logic                   cmd_ready_q, rsp_valid_q, rf_write_q;
    logic [DATAWIDTH-1:0]   rsp_data_q, rf_writeData_q;
    logic [4:0]             rf_readReg1_q, rf_readReg2_q, rf_writeReg_q;
    // Whether a write to this address actually reaches the file
    function automatic logic wr_ok(input logic [4:0] a);
        return !(PROTECT_R0 && a == 5'd0);
    endfunction
    // Captured operands, FILL pointer advance and FILL count of writes really performed
    always_comb begin
        cap_a_d = (PROTECT_R0 && ra_q == 5'd0) ? '0 : rf_readData1;
        cap_b_d = (PROTECT_R0 && rb_q == 5'd0) ? '0 : rf_readData2;
        ptr_d   = ptr_q + 5'd1;
        cnt_d   = cnt_q + {5'd0, rf_write_q};
    end
    // Sequencer FSM; every output is a register loaded on the edge entering the state that shows it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= OP_READ;
            ra_q           <= '0;
            rb_q           <= '0;
            data_q         <= '0;
            a_q            <= '0;
            b_q            <= '0;
            ptr_q          <= '0;
            cnt_q          <= '0;
            cmd_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rf_readReg1_q  <= '0;
            rf_readReg2_q  <= '0;
            rf_writeReg_q  <= '0;
            rf_writeData_q <= '0;
            rf_write_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= cmd_op;
                        ra_q        <= cmd_ra;
                        rb_q        <= cmd_rb;
                        data_q      <= cmd_data;
                        if (cmd_op == OP_FILL) begin
                            state_q        <= FILL;
                            ptr_q          <= cmd_ra;
                            cnt_q          <= '0;
                            rf_write_q     <= wr_ok(cmd_ra);
                            rf_writeReg_q  <= cmd_ra;
                            rf_writeData_q <= cmd_data;
                        end else begin
                            state_q       <= RD;
                            rf_readReg1_q <= cmd_ra;
                            rf_readReg2_q <= cmd_rb;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                RD: begin
                    state_q       <= CAP;
                    rf_readReg1_q <= '0;
                    rf_readReg2_q <= '0;
                end
                CAP: begin
                    a_q <= cap_a_d;
                    b_q <= cap_b_d;
                    if (op_q == OP_READ) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= cap_a_d;
                    end else begin
                        state_q        <= WR1;
                        rf_write_q     <= wr_ok(rb_q);
                        rf_writeReg_q  <= rb_q;
                        rf_writeData_q <= cap_a_d;
                    end
                end
                WR1: begin
                    if (op_q == OP_SWAP) begin
                        state_q        <= WR2;
                        rf_write_q     <= wr_ok(ra_q);
                        rf_writeReg_q  <= ra_q;
                        rf_writeData_q <= b_q;
                    end else begin
                        state_q        <= RESP;
                        rf_write_q     <= 1'b0;
                        rf_writeReg_q  <= '0;
                        rf_writeData_q <= '0;
                        rsp_valid_q    <= 1'b1;
                        rsp_data_q     <= a_q;
                    end
                end
                WR2: begin
                    state_q        <= RESP;
                    rf_write_q     <= 1'b0;
                    rf_writeReg_q  <= '0;
                    rf_writeData_q <= '0;
                    rsp_valid_q    <= 1'b1;
                    rsp_data_q     <= a_q;
                end
                FILL: begin
                    cnt_q <= cnt_d;
                    if (ptr_q == rb_q) begin
                        state_q        <= RESP;
                        rf_write_q     <= 1'b0;
                        rf_writeReg_q  <= '0;
                        rf_writeData_q <= '0;
                        rsp_valid_q    <= 1'b1;
                        rsp_data_q     <= DATAWIDTH'(cnt_d);
                    end else begin
                        ptr_q         <= ptr_d;
                        rf_write_q    <= wr_ok(ptr_d);
                        rf_writeReg_q <= ptr_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rf_readReg1  = rf_readReg1_q;
    assign rf_readReg2  = rf_readReg2_q;
    assign rf_writeReg  = rf_writeReg_q;
    assign rf_writeData = rf_writeData_q;
    assign rf_write     = rf_write_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed tests of regfile_sequencer against a behavioural 2R/1W register file
module tb_regfile_sequencer;
    localparam logic [1:0] OP_READ = 2'd0, OP_COPY = 2'd1, OP_SWAP = 2'd2, OP_FILL = 2'd3;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [4:0]  cmd_ra = '0, cmd_rb = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rf_readReg1, rf_readReg2, rf_writeReg;
    logic [31:0] rf_writeData;
    logic        rf_write;
    logic [31:0] rf_readData1 = '0, rf_readData2 = '0;
    logic [31:0] mem [32] = '{default: 32'd0};
    int          nchk = 0, nerr = 0, cyc = 0;
    logic [4:0]  wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic [31:0] r;
    int          l;
    bit          prot;

    regfile_sequencer #(.DATAWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rf_readReg1(rf_readReg1), .rf_readReg2(rf_readReg2), .rf_writeReg(rf_writeReg),
        .rf_writeData(rf_writeData), .rf_write(rf_write),
        .rf_readData1(rf_readData1), .rf_readData2(rf_readData2)
    );

    always #5 clk = ~clk;

    // Register file: registered reads, write on the same edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_write) mem[rf_writeReg] <= rf_writeData;
        rf_readData1 <= mem[rf_readReg1];
        rf_readData2 <= mem[rf_readReg2];
    end

    // Write log sampled mid-cycle
    always @(negedge clk) begin
        if (rf_write) begin
            wa.push_back(rf_writeReg);
            wd.push_back(rf_writeData);
            wc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_cmd(input logic [1:0] op, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [31:0] d, output logic [31:0] rsp, output int lat);
        int n;
        @(negedge clk);
        wa.delete(); wd.delete(); wc.delete();
        cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_data = d;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        nchk++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready); end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        nchk++; if (rsp_valid !== 1'b1) begin nerr++; $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid); end
        rsp = rsp_data;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        nchk++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        nchk++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        nchk++; if (rsp_data !== 32'd0) begin nerr++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        nchk++; if (rf_write !== 1'b0) begin nerr++; $display("FAIL reset_rf_write: got %b want 0", rf_write); end
        nchk++; if ({rf_readReg1, rf_readReg2, rf_writeReg} !== 15'd0) begin nerr++; $display("FAIL reset_rf_addr: got %h want 0", {rf_readReg1, rf_readReg2, rf_writeReg}); end
        nchk++; if (rf_writeData !== 32'd0) begin nerr++; $display("FAIL reset_rf_wdata: got %h want 0", rf_writeData); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        nchk++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_fill();
        do_cmd(OP_FILL, 5'd3, 5'd5, 32'hA5A5A5A5, r, l);
        nchk++; if (r !== 32'd3) begin nerr++; $display("FAIL fill_rsp: got %0d want 3", r); end
        nchk++; if (l !== 4) begin nerr++; $display("FAIL fill_latency: got %0d want 4", l); end
        nchk++; if (wa.size() !== 3) begin nerr++; $display("FAIL fill_nwrites: got %0d want 3", wa.size()); end
        if (wa.size() == 3) begin
            nchk++; if ({wa[0], wa[1], wa[2]} !== {5'd3, 5'd4, 5'd5}) begin nerr++; $display("FAIL fill_addrs: got %0d,%0d,%0d want 3,4,5", wa[0], wa[1], wa[2]); end
            nchk++; if (wc[2] - wc[0] !== 2) begin nerr++; $display("FAIL fill_consecutive: span %0d want 2", wc[2] - wc[0]); end
            nchk++; if (wd[1] !== 32'hA5A5A5A5) begin nerr++; $display("FAIL fill_wdata: got %h want a5a5a5a5", wd[1]); end
        end
        do_cmd(OP_READ, 5'd4, 5'd0, 32'd0, r, l);
        nchk++; if (r !== 32'hA5A5A5A5) begin nerr++; $display("FAIL read4: got %h want a5a5a5a5", r); end
        nchk++; if (l !== 3) begin nerr++; $display("FAIL read_latency: got %0d want 3", l); end
        nchk++; if (wa.size() !== 0) begin nerr++; $display("FAIL read_nwrites: got %0d want 0", wa.size()); end
    endtask

    task automatic test_copy();
        do_cmd(OP_COPY, 5'd4, 5'd9, 32'd0, r, l);
        nchk++; if (r !== 32'hA5A5A5A5) begin nerr++; $display("FAIL copy_rsp: got %h want a5a5a5a5", r); end
        nchk++; if (l !== 4) begin nerr++; $display("FAIL copy_latency: got %0d want 4", l); end
        nchk++; if (wa.size() !== 1) begin nerr++; $display("FAIL copy_nwrites: got %0d want 1", wa.size()); end
        if (wa.size() == 1) begin
            nchk++; if ({wa[0], wd[0]} !== {5'd9, 32'hA5A5A5A5}) begin nerr++; $display("FAIL copy_write: got r%0d=%h want r9=a5a5a5a5", wa[0], wd[0]); end
        end
        do_cmd(OP_READ, 5'd9, 5'd0, 32'd0, r, l);
        nchk++; if (r !== 32'hA5A5A5A5) begin nerr++; $display("FAIL read9: got %h want a5a5a5a5", r); end
    endtask

    task automatic test_swap();
        do_cmd(OP_FILL, 5'd1, 5'd1, 32'h11, r, l);
        nchk++; if (r !== 32'd1) begin nerr++; $display("FAIL fill_single_rsp: got %0d want 1", r); end
        nchk++; if (l !== 2) begin nerr++; $display("FAIL fill_single_latency: got %0d want 2", l); end
        do_cmd(OP_FILL, 5'd2, 5'd2, 32'h22, r, l);
        do_cmd(OP_SWAP, 5'd1, 5'd2, 32'd0, r, l);
        nchk++; if (r !== 32'h11) begin nerr++; $display("FAIL swap_rsp: got %h want 11", r); end
        nchk++; if (l !== 5) begin nerr++; $display("FAIL swap_latency: got %0d want 5", l); end
        nchk++; if (wa.size() !== 2) begin nerr++; $display("FAIL swap_nwrites: got %0d want 2", wa.size()); end
        if (wa.size() == 2) begin
            nchk++; if ({wa[0], wd[0], wa[1], wd[1]} !== {5'd2, 32'h11, 5'd1, 32'h22}) begin nerr++; $display("FAIL swap_writes: got r%0d=%h r%0d=%h want r2=11 r1=22", wa[0], wd[0], wa[1], wd[1]); end
            nchk++; if (wc[1] - wc[0] !== 1) begin nerr++; $display("FAIL swap_consecutive: gap %0d want 1", wc[1] - wc[0]); end
        end
        do_cmd(OP_READ, 5'd1, 5'd0, 32'd0, r, l);
        nchk++; if (r !== 32'h22) begin nerr++; $display("FAIL read1_after_swap: got %h want 22", r); end
        do_cmd(OP_READ, 5'd2, 5'd0, 32'd0, r, l);
        nchk++; if (r !== 32'h11) begin nerr++; $display("FAIL read2_after_swap: got %h want 11", r); end
    endtask

    task automatic test_fill_wrap();
        do_cmd(OP_FILL, 5'd30, 5'd1, 32'd7, r, l);
        nchk++; if (l !== 5) begin nerr++; $display("FAIL wrap_latency: got %0d want 5", l); end
        if (prot) begin
            nchk++; if (r !== 32'd3) begin nerr++; $display("FAIL wrap_rsp: got %0d want 3", r); end
            nchk++; if (wa.size() !== 3) begin nerr++; $display("FAIL wrap_nwrites: got %0d want 3", wa.size()); end
            if (wa.size() == 3) begin
                nchk++; if ({wa[0], wa[1], wa[2]} !== {5'd30, 5'd31, 5'd1}) begin nerr++; $display("FAIL wrap_addrs: got %0d,%0d,%0d want 30,31,1", wa[0], wa[1], wa[2]); end
            end
        end else begin
            nchk++; if (r !== 32'd4) begin nerr++; $display("FAIL wrap_rsp: got %0d want 4", r); end
            nchk++; if (wa.size() !== 4) begin nerr++; $display("FAIL wrap_nwrites: got %0d want 4", wa.size()); end
            if (wa.size() == 4) begin
                nchk++; if ({wa[0], wa[1], wa[2], wa[3]} !== {5'd30, 5'd31, 5'd0, 5'd1}) begin nerr++; $display("FAIL wrap_addrs: got %0d,%0d,%0d,%0d want 30,31,0,1", wa[0], wa[1], wa[2], wa[3]); end
            end
        end
        do_cmd(OP_READ, 5'd0, 5'd0, 32'd0, r, l);
        nchk++; if (r !== (prot ? 32'd0 : 32'd7)) begin nerr++; $display("FAIL read0_after_wrap: got %h want %h", r, prot ? 32'd0 : 32'd7); end
        do_cmd(OP_READ, 5'd31, 5'd0, 32'd0, r, l);
        nchk++; if (r !== 32'd7) begin nerr++; $display("FAIL read31_after_wrap: got %h want 7", r); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        wa.delete(); wd.delete(); wc.delete();
        cmd_valid = 1'b1; cmd_op = OP_READ; cmd_ra = 5'd4; cmd_rb = 5'd0;
        @(posedge clk);
        @(negedge clk);
        cmd_op = OP_COPY; cmd_ra = 5'd4; cmd_rb = 5'd20;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        nchk++; if (rsp_valid !== 1'b1) begin nerr++; $display("FAIL bp_rsp_timeout: rsp_valid=%b required 1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            nchk++; if ({rsp_valid, cmd_ready} !== 2'b10) begin nerr++; $display("FAIL bp_hold_flags[%0d]: rsp_valid,cmd_ready=%b want 10", i, {rsp_valid, cmd_ready}); end
            nchk++; if (rsp_data !== 32'hA5A5A5A5) begin nerr++; $display("FAIL bp_hold_data[%0d]: got %h want a5a5a5a5", i, rsp_data); end
            @(negedge clk);
        end
        rsp_ready = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        nchk++; if ({rsp_valid, cmd_ready} !== 2'b01) begin nerr++; $display("FAIL bp_release: rsp_valid,cmd_ready=%b want 01", {rsp_valid, cmd_ready}); end
        nchk++; if (wa.size() !== 0) begin nerr++; $display("FAIL bp_pending_accepted: %0d writes want 0", wa.size()); end
    endtask

    task automatic test_reset_mid();
        do_cmd(OP_FILL, 5'd2, 5'd2, 32'd0, r, l);
        @(negedge clk);
        wa.delete(); wd.delete(); wc.delete();
        cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_ra = 5'd0; cmd_rb = 5'd31; cmd_data = 32'h5A;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        nchk++; if (rf_write !== 1'b0) begin nerr++; $display("FAIL midreset_rf_write: got %b want 0", rf_write); end
        nchk++; if ({cmd_ready, rsp_valid, rf_writeReg} !== 7'd0) begin nerr++; $display("FAIL midreset_outputs: got %h want 0", {cmd_ready, rsp_valid, rf_writeReg}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nchk++; if ({rsp_valid, rf_write} !== 2'b00) begin nerr++; $display("FAIL midreset_quiet[%0d]: rsp_valid,rf_write=%b want 00", i, {rsp_valid, rf_write}); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        nchk++; if (wa.size() !== (prot ? 1 : 2)) begin nerr++; $display("FAIL midreset_nwrites: got %0d want %0d", wa.size(), prot ? 1 : 2); end
        nchk++; if ({cmd_ready, rsp_valid} !== 2'b10) begin nerr++; $display("FAIL midreset_idle: cmd_ready,rsp_valid=%b want 10", {cmd_ready, rsp_valid}); end
        do_cmd(OP_READ, 5'd1, 5'd0, 32'd0, r, l);
        nchk++; if (r !== 32'h5A) begin nerr++; $display("FAIL midreset_read1: got %h want 5a", r); end
        do_cmd(OP_READ, 5'd2, 5'd0, 32'd0, r, l);
        nchk++; if (r !== 32'd0) begin nerr++; $display("FAIL midreset_read2: got %h want 0", r); end
    endtask

    initial begin
`ifdef REGFILE_SEQ_PROTECT_R0_EN
        prot = 1'b1;
`else
        prot = 1'b0;
`endif
        test_reset();
        test_fill();
        test_copy();
        test_swap();
        test_fill_wrap();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Command-driven initiator for the 32-entry, 2-read/1-write register file. It drives the file's read-address, write-address, write-data and write-enable pins, and consumes its two read-data outputs.
- Accepts one command at a time over a valid/ready channel: READ, COPY, SWAP or FILL.
- Sequences the required port accesses, accounting for the file's one-cycle registered read latency.
- Returns exactly one response per command over a valid/ready channel.
- Used by the test/debug path and by init logic to preload and inspect architectural registers.

Parameters:
- DATAWIDTH, 32, width of register data, cmd_data and rsp_data.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when high together with cmd_valid at a clk edge.
- cmd_op  input  2  00 READ, 01 COPY, 10 SWAP, 11 FILL.
- cmd_ra  input  5  register A (READ source, COPY source, SWAP first, FILL start).
- cmd_rb  input  5  register B (COPY destination, SWAP second, FILL end inclusive).
- cmd_data  input  DATAWIDTH  FILL value.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when high together with rsp_valid at a clk edge.
- rsp_data  output  DATAWIDTH  response payload.
- rf_readReg1  output  5  to register-file read port 1.
- rf_readReg2  output  5  to register-file read port 2.
- rf_writeReg  output  5  to register-file write address.
- rf_writeData  output  DATAWIDTH  to register-file write data.
- rf_write  output  1  to register-file write enable.
- rf_readData1  input  DATAWIDTH  from register-file port 1; valid the cycle after its address was sampled.
- rf_readData2  input  DATAWIDTH  from register-file port 2; same timing.

Behaviour:
- Interface timing is decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; operand registers, captured A/B, FILL pointer, FILL count and rsp_data all 0; rf_* outputs 0; rsp_valid 0. cmd_ready is 0 while rst_n is low and 1 in IDLE after release.
- All outputs decode from registered state and operand registers only. There is no combinational path from cmd_* or rf_readData* to any output.
- States and transitions:
  - IDLE: cmd_ready=1. On accept, latch op/ra/rb/data. FILL goes to FILL with ptr=ra and count=0; all other ops go to RD.
  - RD: rf_readReg1=ra, rf_readReg2=rb. Next state CAP.
  - CAP: capture A=rf_readData1, B=rf_readData2. READ goes to RESP with rsp_data=A. COPY and SWAP go to WR1.
  - WR1: rf_write=1, rf_writeReg=rb, rf_writeData=A. SWAP goes to WR2; COPY goes to RESP with rsp_data=A.
  - WR2: rf_write=1, rf_writeReg=ra, rf_writeData=B. Next state RESP with rsp_data=A (old value of ra).
  - FILL: rf_write=1, rf_writeReg=ptr, rf_writeData=data. Each edge: count+1. If ptr==rb, go to RESP with rsp_data=count+1, zero-extended. Otherwise ptr=ptr+1 mod 32.
  - RESP: rsp_valid=1, rsp_data held stable. On rsp_ready, go to IDLE.
- Latency from the accept edge to the first rsp_valid cycle: READ 3 cycles, COPY 4, SWAP 5, FILL of n registers n+1.
- rf_write is high for exactly one cycle per register written and low in all other states.
- FILL wrap-around:
  - ra>rb wraps through 31 to 0, e.g. ra=30, rb=1 writes 30,31,0,1.
  - ra==rb writes one register.
  - ra=0, rb=31 writes 32 registers, count=32. The count register is 6 bits.
- COPY or SWAP with ra==rb performs the write(s) with unchanged values.
- Never reads and writes in the same cycle, so the register file's write-priority bypass is never exercised.
- Backpressure: while in RESP with rsp_ready low, hold every output stable. cmd_ready=0 in all non-IDLE states.
- Reset mid-operation: all outputs return to reset values immediately and the command is abandoned. Writes already committed remain; no further writes occur and no response is produced.

Optional Feature:
- Macro: REGFILE_SEQ_PROTECT_R0_EN.
- When defined:
  - Any write whose target is register 0 is suppressed: rf_write stays 0 that cycle, but the state still advances.
  - FILL count excludes suppressed writes.
  - READ of register 0 returns 0 regardless of rf_readData1.
  - COPY/SWAP sourcing register 0 use value 0.
- When not defined, register 0 is an ordinary register.

Test Plan:
- FILL ra=3 rb=5 data=0xA5A5A5A5 after reset -> rf_write high 3 consecutive cycles, addresses 3,4,5; rsp_data=3. Then READ ra=4 -> rsp_valid 3 cycles after accept, rsp_data=0xA5A5A5A5.
- COPY ra=4 rb=9 -> single write cycle to 9 with 0xA5A5A5A5; rsp_data=0xA5A5A5A5. A following READ 9 returns 0xA5A5A5A5.
- Preload r1=0x11, r2=0x22, then SWAP ra=1 rb=2 -> writes r2=0x11 then r1=0x22 in consecutive cycles; rsp_data=0x11.
- FILL ra=30 rb=1 data=7 -> writes 30,31,0,1; rsp_data=4. With REGFILE_SEQ_PROTECT_R0_EN: no write to 0, rsp_data=3, READ 0 returns 0.
- READ with rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, pending cmd_valid not accepted. Raise rsp_ready -> IDLE next cycle.
- FILL ra=0 rb=31 with rst_n pulled low after 2 write cycles -> rf_write drops asynchronously, no response. After release, READ 1 returns data and READ 2 returns 0.
